// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with hold/flush control
// and saturating stall/flush statistics counters.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              hold,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic in_xfer;
    logic out_xfer;
    logic stall_inc;
    logic flush_inc;

    assign in_ready  = (state_q != S_FULL)  && !hold && !flush;
    assign out_valid = (state_q != S_EMPTY) && !hold && !flush;
    assign out_data  = main_q;
    assign in_xfer   = in_valid  && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else if (flush) begin
            state_q <= S_EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else if (!hold) begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= in_data;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        skid_q  <= in_data;
                        state_q <= S_FULL;
                    end else if (out_xfer) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        state_q <= S_ONE;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    // Stall counts any cycle a live entry fails to leave, hold included.
    assign stall_inc = (state_q != S_EMPTY) && !flush && (hold || !out_ready);
    assign flush_inc = (state_q != S_EMPTY) && flush;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
        if (flush_inc && (flush_q != CNT_MAX)) flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_reg;

    localparam logic [63:0] FV = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [15:0] stall_cnt, flush_cnt;
    logic        in_ready_s, out_valid_s;
    logic [63:0] out_data_s;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    pipe_stage_reg #(.DATA_W(64), .FLUSH_VAL(FV), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .hold(hold), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .FLUSH_VAL(FV), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .out_valid(out_valid_s), .out_data(out_data_s),
        .out_ready(out_ready), .hold(hold), .flush(flush),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model: FIFO of live entries plus saturating counters.
    logic [63:0] q[$];
    logic [63:0] last_pop = FV;
    int m_stall = 0, m_flush = 0, m_stall_s = 0, m_flush_s = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int inc_sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_reset();
        q.delete();
        last_pop  = FV;
        m_stall   = 0;
        m_flush   = 0;
        m_stall_s = 0;
        m_flush_s = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int  n;
        bit  ix, ox;
        if (!rst_n) begin
            model_reset();
        end else begin
            n = q.size();
            if (flush) begin
                if (n > 0) begin
                    m_flush   = inc_sat(m_flush, 65535);
                    m_flush_s = inc_sat(m_flush_s, 3);
                end
                q.delete();
                last_pop = FV;
            end else begin
                if (n > 0 && (hold || !out_ready)) begin
                    m_stall   = inc_sat(m_stall, 65535);
                    m_stall_s = inc_sat(m_stall_s, 3);
                end
                if (!hold) begin
                    ix = in_valid && (n < 2);
                    ox = out_ready && (n > 0);
                    if (ox) last_pop = q.pop_front();
                    if (ix) q.push_back(in_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        int   n;
        logic exp_ir, exp_ov;
        n      = q.size();
        exp_ir = (n < 2) && !hold && !flush;
        exp_ov = (n > 0) && !hold && !flush;
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready_s", in_ready_s, exp_ir);
        chk("out_valid_s", out_valid_s, exp_ov);
        if (n > 0) begin
            chk("out_data", out_data, q[0]);
        end else begin
            checks++;
            if (out_data !== FV && out_data !== last_pop) begin
                errs++;
                $display("FAIL out_data_empty: got %0h expected %0h or %0h", out_data, FV, last_pop);
            end
        end
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("stall_cnt_s", stall_cnt_s, m_stall_s);
        chk("flush_cnt_s", flush_cnt_s, m_flush_s);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [63:0] d, input logic ordy,
                         input logic h, input logic f);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        hold      = h;
        flush     = f;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    localparam logic [63:0] A = 64'h1111_0000_0000_000A;
    localparam logic [63:0] B = 64'h2222_0000_0000_000B;
    localparam logic [63:0] C = 64'h3333_0000_0000_000C;
    localparam logic [63:0] D = 64'h4444_0000_0000_000D;

    initial begin
        #13 rst_n = 1'b1;

        // Reset state
        do_reset();
        drive(0, '0, 1, 0, 0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, FV);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_flush", flush_cnt, 16'd0);

        // Streaming
        drive(1, A, 1, 0, 0); tick();
        drive(1, B, 1, 0, 0);
        chk("str_v0", out_valid, 1'b1); chk("str_d0", out_data, A);
        tick();
        drive(1, C, 1, 0, 0); chk("str_d1", out_data, B);
        tick();
        drive(0, '0, 1, 0, 0); chk("str_d2", out_data, C);
        tick();
        chk("str_empty", out_valid, 1'b0); chk("str_stall", stall_cnt, 16'd0);

        // Backpressure
        do_reset();
        drive(1, A, 0, 0, 0); tick();
        drive(1, B, 0, 0, 0); chk("bp_ir_one", in_ready, 1'b1);
        tick();
        drive(1, C, 0, 0, 0);
        chk("bp_ir_full", in_ready, 1'b0); chk("bp_ov_full", out_valid, 1'b1);
        chk("bp_d_full", out_data, A);
        tick();
        drive(0, '0, 1, 0, 0);
        chk("bp_d0", out_data, A); chk("bp_stall_full", stall_cnt, 16'd2);
        tick();
        chk("bp_d1", out_data, B); chk("bp_v1", out_valid, 1'b1);
        tick();
        chk("bp_empty", out_valid, 1'b0); chk("bp_stall", stall_cnt, 16'd2);

        // Hold
        do_reset();
        drive(1, A, 1, 0, 0); tick();
        drive(0, '0, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            chk("hold_ov", out_valid, 1'b0); chk("hold_ir", in_ready, 1'b0);
            tick();
        end
        drive(0, '0, 1, 0, 0);
        chk("hold_ov_after", out_valid, 1'b1); chk("hold_d", out_data, A);
        chk("hold_stall", stall_cnt, 16'd3);
        tick();
        chk("hold_empty", out_valid, 1'b0);

        // Flush over hold in FULL with coincident input
        do_reset();
        drive(1, A, 0, 0, 0); tick();
        drive(1, B, 0, 0, 0); tick();
        drive(1, C, 0, 1, 1);
        chk("fl_ir", in_ready, 1'b0); chk("fl_ov", out_valid, 1'b0);
        tick();
        drive(0, '0, 1, 0, 0);
        chk("fl_ov_after", out_valid, 1'b0); chk("fl_d", out_data, FV);
        chk("fl_cnt", flush_cnt, 16'd1);
        tick();
        chk("fl_not_stored", out_valid, 1'b0);

        // Saturation of the narrow counter
        do_reset();
        drive(1, A, 0, 0, 0); tick();
        drive(0, '0, 0, 0, 0);
        repeat (6) tick();
        chk("sat_small", stall_cnt_s, 2'd3); chk("sat_wide", stall_cnt, 16'd6);
        chk("sat_d", out_data, A);

        // Async reset between edges while FULL
        do_reset();
        drive(1, A, 0, 0, 0); tick();
        drive(1, B, 0, 0, 0); tick();
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ov", out_valid, 1'b0); chk("ar_stall", stall_cnt, 16'd0);
        chk("ar_flush", flush_cnt, 16'd0); chk("ar_stall_s", stall_cnt_s, 2'd0);
        rst_n = 1'b1;
        drive(1, D, 1, 0, 0);
        chk("ar_ir", in_ready, 1'b1);
        tick();
        drive(0, '0, 1, 0, 0);
        chk("ar_ov_push", out_valid, 1'b1); chk("ar_d_push", out_data, D);
        tick();

        // Randomized traffic, alternating drain-heavy and backpressure-heavy phases
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) < ((i % 1000) < 500 ? 3 : 1));
            hold      = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 249) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        drive(0, '0, 1, 0, 0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
